// File: rtl/output_credit_tracker_if.sv
// Bundle between the switch/VC allocators and one output port's credit tracker.
// The router side drives the grants, credit returns and claims; the tracker drives back registered counts and flags.
interface output_credit_tracker_if #(
   parameter int NUM_VCS          = 2,
   parameter int VC_ID_BITS       = 1,
   parameter int CREDIT_CTR_WIDTH = 3
);
   logic                                      op_grant_i;
   logic [VC_ID_BITS-1:0]                     vc_sel_i;
   logic                                      tail_i;
   logic                                      credit_valid_i;
   logic [VC_ID_BITS-1:0]                     credit_vc_i;
   logic                                      vc_claim_valid_i;
   logic [VC_ID_BITS-1:0]                     vc_claim_id_i;
   logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]  credits_avail_count_r;
   logic [NUM_VCS-1:0]                        vc_idle_r;
   logic                                      credit_err_r;

   modport master (
      output op_grant_i, vc_sel_i, tail_i, credit_valid_i, credit_vc_i,
             vc_claim_valid_i, vc_claim_id_i,
      input  credits_avail_count_r, vc_idle_r, credit_err_r
   );

   modport slave (
      input  op_grant_i, vc_sel_i, tail_i, credit_valid_i, credit_vc_i,
             vc_claim_valid_i, vc_claim_id_i,
      output credits_avail_count_r, vc_idle_r, credit_err_r
   );
endinterface

// File: rtl/output_credit_tracker.sv
// Per-VC downstream credit counters and IDLE/ACTIVE/DRAIN state for one output port.
// Latency: one cycle from any event to the registered outputs. No backpressure: every event is taken in its cycle.
module output_credit_tracker #(
   parameter int NUM_VCS          = 2,
   parameter int VC_ID_BITS       = 1,
   parameter int BUFFER_DEPTH     = 4,
   parameter int CREDIT_CTR_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    arst_n,
   output_credit_tracker_if.slave  bus
);

   typedef enum logic [1:0] {VC_IDLE, VC_ACTIVE, VC_DRAIN} vc_state_t;

   localparam logic [CREDIT_CTR_WIDTH-1:0] FULL = CREDIT_CTR_WIDTH'(BUFFER_DEPTH);

   logic [NUM_VCS-1:0]                        dec;
   logic [NUM_VCS-1:0]                        inc;
   logic [NUM_VCS-1:0]                        claim;
   logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]  nxt_cnt;
   logic                                      err_evt;
   vc_state_t                                 state [NUM_VCS];

   // An out-of-range VC index decodes to no VC, so the event is dropped and only flagged.
   always_comb begin
      dec   = '0;
      inc   = '0;
      claim = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         dec[v]   = bus.op_grant_i       && (bus.vc_sel_i      == VC_ID_BITS'(v));
         inc[v]   = bus.credit_valid_i   && (bus.credit_vc_i   == VC_ID_BITS'(v));
         claim[v] = bus.vc_claim_valid_i && (bus.vc_claim_id_i == VC_ID_BITS'(v));
      end
   end

   always_comb begin
      nxt_cnt = bus.credits_avail_count_r;
      err_evt = (bus.op_grant_i && !(|dec)) ||
                (bus.credit_valid_i && !(|inc)) ||
                (bus.vc_claim_valid_i && !(|claim));
      for (int v = 0; v < NUM_VCS; v++) begin
         if (dec[v] && !inc[v]) begin
            if (bus.credits_avail_count_r[v] == '0) err_evt = 1'b1;
            else nxt_cnt[v] = bus.credits_avail_count_r[v] - 1'b1;
         end else if (inc[v] && !dec[v]) begin
            if (bus.credits_avail_count_r[v] == FULL) err_evt = 1'b1;
            else nxt_cnt[v] = bus.credits_avail_count_r[v] + 1'b1;
         end
         if (claim[v] && state[v] != VC_IDLE) err_evt = 1'b1;
         if (dec[v] && state[v] == VC_IDLE && !claim[v]) err_evt = 1'b1;
         if (dec[v] && state[v] == VC_DRAIN) err_evt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int v = 0; v < NUM_VCS; v++) state[v] <= VC_IDLE;
         bus.credits_avail_count_r <= {NUM_VCS{FULL}};
         bus.vc_idle_r             <= '1;
         bus.credit_err_r          <= 1'b0;
      end else begin
         bus.credits_avail_count_r <= nxt_cnt;
         bus.credit_err_r          <= bus.credit_err_r | err_evt;
         for (int v = 0; v < NUM_VCS; v++) begin
            // A claim on a busy VC freezes that VC's state for the cycle.
            case (state[v])
               VC_IDLE: begin
                  if (claim[v]) begin
                     state[v]         <= (dec[v] && bus.tail_i) ? VC_DRAIN : VC_ACTIVE;
                     bus.vc_idle_r[v] <= 1'b0;
                  end
               end
               VC_ACTIVE: begin
                  if (!claim[v] && dec[v] && bus.tail_i) state[v] <= VC_DRAIN;
               end
               VC_DRAIN: begin
                  if (!claim[v] && nxt_cnt[v] == FULL) begin
                     state[v]         <= VC_IDLE;
                     bus.vc_idle_r[v] <= 1'b1;
                  end
               end
               default: begin
                  state[v]         <= VC_IDLE;
                  bus.vc_idle_r[v] <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
